// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Accept-to-response latency is N+1 cycles (N=1, or MULDIV_CYCLES for MUL/DIV); one op in flight, and a response stalls the block until it is taken.
module alu_arbiter #(
    parameter int DATAWIDTH     = 32,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req0_valid_i,
    output logic                 req0_ready_o,
    input  logic [DATAWIDTH-1:0] req0_a_i,
    input  logic [DATAWIDTH-1:0] req0_b_i,
    input  logic [3:0]           req0_op_i,
    input  logic                 req1_valid_i,
    output logic                 req1_ready_o,
    input  logic [DATAWIDTH-1:0] req1_a_i,
    input  logic [DATAWIDTH-1:0] req1_b_i,
    input  logic [3:0]           req1_op_i,
    output logic                 rsp0_valid_o,
    input  logic                 rsp0_ready_i,
    output logic [DATAWIDTH-1:0] rsp0_data_o,
    output logic                 rsp0_err_o,
    output logic                 rsp1_valid_o,
    input  logic                 rsp1_ready_i,
    output logic [DATAWIDTH-1:0] rsp1_data_o,
    output logic                 rsp1_err_o,
    output logic [DATAWIDTH-1:0] alu_a_o,
    output logic [DATAWIDTH-1:0] alu_b_o,
    output logic [3:0]           alu_op_o,
    input  logic [DATAWIDTH-1:0] alu_out_i,
    output logic                 busy_o
);
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_LW   = 4'd1;
    localparam logic [3:0] OP_SW   = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_MUL  = 4'd4;
    localparam logic [3:0] OP_DIV  = 4'd5;
    localparam logic [3:0] OP_AND  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_BEQ  = 4'd9;
    localparam logic [3:0] OP_BGT  = 4'd10;
    localparam logic [3:0] OP_BGE  = 4'd11;
    localparam logic [3:0] OP_JMP  = 4'd12;
    localparam logic [3:0] OP_ADDI = 4'd13;

    localparam int CW = (MULDIV_CYCLES < 2) ? 1 : $clog2(MULDIV_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MULDIV = CW'(MULDIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    typedef struct packed {
        logic [DATAWIDTH-1:0] a;
        logic [DATAWIDTH-1:0] b;
        logic [3:0]           op;
    } alu_req_t;

    state_t               state_q, state_d;
    alu_req_t             alu_q, alu_d;
    alu_req_t             req_sel;
    logic                 last_grant_q, last_grant_d;
    logic [CW-1:0]        count_q, count_d;
    logic [DATAWIDTH-1:0] data_q, data_d;
    logic                 err_q, err_d;
    logic                 grant;
    logic                 accept;
    logic                 rsp_hs;
    logic                 in_resp;

    // last_grant_q doubles as the owner of the transaction in flight
    always_comb begin
        grant   = (req0_valid_i & req1_valid_i) ? ~last_grant_q : req1_valid_i;
        req_sel = grant ? '{a: req1_a_i, b: req1_b_i, op: req1_op_i}
                        : '{a: req0_a_i, b: req0_b_i, op: req0_op_i};
        accept  = (state_q == S_IDLE) & (req0_valid_i | req1_valid_i);
        in_resp = (state_q == S_RESP);
        rsp_hs  = in_resp & (last_grant_q ? rsp1_ready_i : rsp0_ready_i);
    end

    always_comb begin
        state_d      = state_q;
        alu_d        = alu_q;
        last_grant_d = last_grant_q;
        count_d      = count_q;
        data_d       = data_q;
        err_d        = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    alu_d        = req_sel;
                    last_grant_d = grant;
                    count_d      = (req_sel.op == OP_MUL || req_sel.op == OP_DIV) ? CNT_MULDIV : CNT_ONE;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                count_d = count_q - CNT_ONE;
                if (count_q == CNT_ONE) begin
                    state_d = S_RESP;
                    if (!(alu_q.op inside {OP_ADD, OP_LW, OP_SW, OP_SUB, OP_MUL, OP_DIV, OP_AND,
                                           OP_OR, OP_XOR, OP_BEQ, OP_BGT, OP_BGE, OP_JMP, OP_ADDI})) begin
                        data_d = '0;
                        err_d  = 1'b1;
                    end else if (alu_q.op == OP_DIV && alu_q.b == '0) begin
                        data_d = '1;
                        err_d  = 1'b1;
                    end else begin
                        data_d = alu_out_i;
                        err_d  = 1'b0;
                    end
                end
            end
            S_RESP: begin
                if (rsp_hs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            alu_q        <= '0;
            last_grant_q <= 1'b1;
            count_q      <= '0;
            data_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            alu_q        <= alu_d;
            last_grant_q <= last_grant_d;
            count_q      <= count_d;
            data_q       <= data_d;
            err_q        <= err_d;
        end
    end

    // Readiness is combinational, so reset has to mask it directly
    assign req0_ready_o = ~rst_i & (state_q == S_IDLE) & req0_valid_i & ~grant;
    assign req1_ready_o = ~rst_i & (state_q == S_IDLE) & req1_valid_i & grant;
    assign rsp0_valid_o = in_resp & ~last_grant_q;
    assign rsp1_valid_o = in_resp & last_grant_q;
    assign rsp0_data_o  = last_grant_q ? '0 : data_q;
    assign rsp1_data_o  = last_grant_q ? data_q : '0;
    assign rsp0_err_o   = rsp0_valid_o & err_q;
    assign rsp1_err_o   = rsp1_valid_o & err_q;
    assign alu_a_o      = alu_q.a;
    assign alu_b_o      = alu_q.b;
    assign alu_op_o     = alu_q.op;
    assign busy_o       = (state_q != S_IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed checks of alu_arbiter against a transaction-level model.
module tb_alu_arbiter;
    localparam int DW = 32;
    localparam int MD = 4;
    localparam logic [3:0] OP_ADD = 4'd0, OP_LW = 4'd1, OP_SW = 4'd2, OP_SUB = 4'd3,
                           OP_MUL = 4'd4, OP_DIV = 4'd5, OP_AND = 4'd6, OP_OR = 4'd7,
                           OP_XOR = 4'd8, OP_BEQ = 4'd9, OP_BGT = 4'd10, OP_BGE = 4'd11,
                           OP_JMP = 4'd12, OP_ADDI = 4'd13;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [DW-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [3:0]    op0 = '0, op1 = '0;
    logic          rsp0_valid, rsp1_valid;
    logic          rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [DW-1:0] rsp0_data, rsp1_data;
    logic          rsp0_err, rsp1_err;
    logic [DW-1:0] alu_a, alu_b, alu_out;
    logic [3:0]    alu_op;
    logic          busy;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATAWIDTH(DW), .MULDIV_CYCLES(MD)) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready),
        .req0_a_i(a0), .req0_b_i(b0), .req0_op_i(op0),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready),
        .req1_a_i(a1), .req1_b_i(b1), .req1_op_i(op1),
        .rsp0_valid_o(rsp0_valid), .rsp0_ready_i(rsp0_ready),
        .rsp0_data_o(rsp0_data), .rsp0_err_o(rsp0_err),
        .rsp1_valid_o(rsp1_valid), .rsp1_ready_i(rsp1_ready),
        .rsp1_data_o(rsp1_data), .rsp1_err_o(rsp1_err),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
        .alu_out_i(alu_out), .busy_o(busy)
    );

    // Stand-in ALU; divide by zero returns a marker the arbiter must override
    function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [3:0] op);
        case (op)
            OP_ADD, OP_LW, OP_SW, OP_ADDI: return a + b;
            OP_SUB: return a - b;
            OP_MUL: return a * b;
            OP_DIV: return (b == 0) ? 32'hDEAD_BEEF : a / b;
            OP_AND: return a & b;
            OP_OR:  return a | b;
            OP_XOR: return a ^ b;
            OP_BEQ: return {31'd0, a == b};
            OP_BGT: return {31'd0, a > b};
            OP_BGE: return {31'd0, a >= b};
            OP_JMP: return a;
            default: return 32'h0BAD_0BAD;
        endcase
    endfunction

    assign alu_out = alu_fn(alu_a, alu_b, alu_op);

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: who owns the ALU, when its answer is due, what it is
    bit            m_busy = 1'b0;
    bit            m_last = 1'b1;
    bit            m_owner = 1'b0;
    int            m_resp_at = 0;
    logic [DW-1:0] m_data = '0;
    bit            m_err = 1'b0;
    logic [DW-1:0] m_alu_a = '0, m_alu_b = '0;
    logic [3:0]    m_alu_op = '0;
    bit            g, e_rdy0, e_rdy1, e_v0, e_v1;
    logic [DW-1:0] sa, sb;
    logic [3:0]    sop;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ready0", req0_ready, 0);
            chk("rst_ready1", req1_ready, 0);
            chk("rst_rsp0_valid", rsp0_valid, 0);
            chk("rst_rsp1_valid", rsp1_valid, 0);
            chk("rst_err", {rsp1_err, rsp0_err}, 0);
            chk("rst_busy", busy, 0);
            chk("rst_alu_a", alu_a, 0);
            chk("rst_alu_b", alu_b, 0);
            chk("rst_alu_op", alu_op, 0);
            chk("rst_data", rsp0_data | rsp1_data, 0);
            m_busy = 1'b0; m_last = 1'b1;
            m_alu_a = '0; m_alu_b = '0; m_alu_op = '0;
        end else begin
            e_rdy0 = 1'b0; e_rdy1 = 1'b0; e_v0 = 1'b0; e_v1 = 1'b0; g = 1'b0;
            if (!m_busy) begin
                g = (req0_valid && req1_valid) ? !m_last : req1_valid;
                e_rdy0 = req0_valid && !g;
                e_rdy1 = req1_valid && g;
            end else if (cyc >= m_resp_at) begin
                e_v0 = !m_owner;
                e_v1 = m_owner;
            end
            chk("ready0", req0_ready, e_rdy0);
            chk("ready1", req1_ready, e_rdy1);
            chk("rsp0_valid", rsp0_valid, e_v0);
            chk("rsp1_valid", rsp1_valid, e_v1);
            chk("busy", busy, m_busy);
            chk("alu_a", alu_a, m_alu_a);
            chk("alu_b", alu_b, m_alu_b);
            chk("alu_op", alu_op, m_alu_op);
            if (e_v0) begin
                chk("rsp0_data", rsp0_data, m_data);
                chk("rsp0_err", rsp0_err, m_err);
            end
            if (e_v1) begin
                chk("rsp1_data", rsp1_data, m_data);
                chk("rsp1_err", rsp1_err, m_err);
            end
            if (!m_busy && (req0_valid || req1_valid)) begin
                sa  = g ? a1 : a0;
                sb  = g ? b1 : b0;
                sop = g ? op1 : op0;
                m_busy = 1'b1; m_owner = g; m_last = g;
                m_resp_at = cyc + ((sop == OP_MUL || sop == OP_DIV) ? MD : 1) + 1;
                m_alu_a = sa; m_alu_b = sb; m_alu_op = sop;
                if (sop > OP_ADDI) begin
                    m_data = '0; m_err = 1'b1;
                end else if (sop == OP_DIV && sb == 0) begin
                    m_data = '1; m_err = 1'b1;
                end else begin
                    m_data = alu_fn(sa, sb, sop); m_err = 1'b0;
                end
            end else if (m_busy && cyc >= m_resp_at && (m_owner ? rsp1_ready : rsp0_ready)) begin
                m_busy = 1'b0;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
    endtask

    // Issue one op on req0, wait for its response; leaves the bench in the next cycle
    task automatic run_op0(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [3:0] op,
                           output logic [DW-1:0] d, output logic e);
        int k;
        a0 = a; b0 = b; op0 = op; req0_valid = 1'b1;
        d = 'x; e = 1'bx;
        for (k = 0; k < 40; k++) begin
            smp();
            if (req0_ready) break;
            tick();
        end
        tick();
        req0_valid = 1'b0;
        for (k = 0; k < 40; k++) begin
            smp();
            if (rsp0_valid) break;
            tick();
        end
        if (k == 40) chk("run_op0_timeout", 1, 0);
        d = rsp0_data; e = rsp0_err;
        tick();
    endtask

    logic [DW-1:0] q_gnt[$];
    logic [DW-1:0] q_acc[$];
    logic [DW-1:0] q_dat[$];
    logic [DW-1:0] rd;
    logic          re;
    logic [DW-1:0] exp_gnt[4];
    logic [DW-1:0] exp_dat[4];

    initial begin
        exp_gnt[0] = 0;          exp_gnt[1] = 1;          exp_gnt[2] = 0;          exp_gnt[3] = 1;
        exp_dat[0] = 32'd7;      exp_dat[1] = 32'hFF;     exp_dat[2] = 32'd7;      exp_dat[3] = 32'hFF;
        tick();
        do_reset();

        // Single ADD on req0: ready at once, response two cycles later
        req0_valid = 1'b1; a0 = 5; b0 = 7; op0 = OP_ADD;
        smp(); chk("t1_ready0", req0_ready, 1);
        tick(); req0_valid = 1'b0;
        smp(); chk("t1_rsp0_early", rsp0_valid, 0);
        tick();
        smp();
        chk("t1_rsp0_valid", rsp0_valid, 1);
        chk("t1_data", rsp0_data, 12);
        chk("t1_err", rsp0_err, 0);
        chk("t1_rsp1_valid", rsp1_valid, 0);
        tick();

        // Both requesters always valid: strict alternation, one accept every 3 cycles
        do_reset();
        req0_valid = 1'b1; a0 = 10;    b0 = 3;    op0 = OP_SUB;
        req1_valid = 1'b1; a1 = 'hF0;  b1 = 'h0F; op1 = OP_XOR;
        for (int c = 0; c < 12; c++) begin
            smp();
            if (req0_ready) begin q_gnt.push_back(0); q_acc.push_back(c); end
            if (req1_ready) begin q_gnt.push_back(1); q_acc.push_back(c); end
            if (rsp0_valid) q_dat.push_back(rsp0_data);
            if (rsp1_valid) q_dat.push_back(rsp1_data);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_grant", (i < q_gnt.size()) ? q_gnt[i] : 'x, exp_gnt[i]);
            chk("t2_data", (i < q_dat.size()) ? q_dat[i] : 'x, exp_dat[i]);
            chk("t2_accept_cycle", (i < q_acc.size()) ? q_acc[i] : 'x, 3 * i);
        end

        // MUL on req1: operands held on the ALU through the whole window
        do_reset();
        req1_valid = 1'b1; a1 = 6; b1 = 7; op1 = OP_MUL;
        smp(); chk("t3_ready1", req1_ready, 1);
        tick(); req1_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            smp();
            chk("t3_rsp1_early", rsp1_valid, 0);
            chk("t3_alu_a", alu_a, 6);
            chk("t3_alu_b", alu_b, 7);
            chk("t3_alu_op", alu_op, OP_MUL);
            tick();
        end
        smp();
        chk("t3_rsp1_valid", rsp1_valid, 1);
        chk("t3_data", rsp1_data, 42);
        tick();

        // Error cases
        run_op0(9, 0, OP_DIV, rd, re);
        chk("t4_div0_data", rd, 32'hFFFF_FFFF);
        chk("t4_div0_err", re, 1);
        run_op0(3, 4, 4'hE, rd, re);
        chk("t4_illegal_data", rd, 0);
        chk("t4_illegal_err", re, 1);
        run_op0(9, 3, OP_DIV, rd, re);
        chk("t4_div_data", rd, 3);
        chk("t4_div_err", re, 0);

        // Response backpressure blocks the other requester
        do_reset();
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; a0 = 1; b0 = 2; op0 = OP_ADD;
        req1_valid = 1'b1; a1 = 'hC; b1 = 'hA; op1 = OP_AND;
        smp(); chk("t5_ready0", req0_ready, 1); chk("t5_ready1_c0", req1_ready, 0);
        tick(); req0_valid = 1'b0;
        smp(); chk("t5_ready1_c1", req1_ready, 0);
        tick();
        for (int c = 2; c < 12; c++) begin
            smp();
            chk("t5_rsp0_held", rsp0_valid, 1);
            chk("t5_data_held", rsp0_data, 3);
            chk("t5_ready1_blocked", req1_ready, 0);
            tick();
        end
        rsp0_ready = 1'b1;
        smp(); chk("t5_ready1_hs", req1_ready, 0);
        tick();
        smp(); chk("t5_ready1_after", req1_ready, 1);
        tick(); req1_valid = 1'b0;
        repeat (4) tick();

        // Reset in the middle of a DIV drops it
        do_reset();
        req0_valid = 1'b1; a0 = 100; b0 = 5; op0 = OP_DIV;
        smp(); tick(); req0_valid = 1'b0;
        smp(); tick();
        rst = 1'b1;
        smp();
        chk("t6_busy", busy, 0);
        chk("t6_alu_a", alu_a, 0);
        chk("t6_alu_b", alu_b, 0);
        chk("t6_alu_op", alu_op, 0);
        chk("t6_rsp0_valid", rsp0_valid, 0);
        tick(); rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            smp();
            chk("t6_no_rsp", {rsp1_valid, rsp0_valid}, 0);
            tick();
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        smp(); chk("t6_tie_ready0", req0_ready, 1); chk("t6_tie_ready1", req1_ready, 0);
        tick(); req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (6) tick();

        // Random traffic, judged entirely by the model
        for (int c = 0; c < 4000; c++) begin
            rst        = ($urandom_range(0, 499) == 0);
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            a0  = $urandom; a1 = $urandom;
            b0  = ($urandom_range(0, 5) == 0) ? '0 : $urandom;
            b1  = ($urandom_range(0, 5) == 0) ? '0 : $urandom;
            op0 = 4'($urandom_range(0, 15));
            op1 = 4'($urandom_range(0, 15));
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
